// File: rtl/nibble_enc_arbiter.sv
// Two-channel nibble XOR encoder: packet-locked round-robin arbitration over one
// shared FourbitEncoder, per-channel rolling keys and a registered valid/ready output.
// Optional plaintext parity check is enabled by defining NIBBLE_ENC_PARITY_EN.

module FourbitEncoder (
  input  logic [3:0] data,
  input  logic [3:0] key,
  output logic [3:0] enc
);
  assign enc = data ^ key;
endmodule

module nibble_enc_arbiter #(
  parameter bit          KEY_ROTATE = 1'b1,
  parameter logic [3:0]  RESET_KEY  = 4'h0,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_word,
  input  logic       req0_last,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_word,
  input  logic       req1_last,
  input  logic       key_load,
  input  logic       key_sel,
  input  logic [3:0] key_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_word,
  output logic       out_ch,
  output logic       out_last,
`ifdef NIBBLE_ENC_PARITY_EN
  input  logic       req0_par,
  input  logic       req1_par,
  output logic       out_err,
`endif
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  // Channel that wins a tie; after every exit it points at the channel not just served.
  logic            rr_prio;
  logic [3:0]      burst_cnt;
  logic [1:0][3:0] base_key;
  logic [1:0][3:0] work_key;
  logic [1:0]      mid_packet;

  logic       slot_free;
  logic       grant;
  logic       win;
  logic       acc;
  logic       acc_ch;
  logic [3:0] acc_word;
  logic       acc_last;
  logic       burst_hit;
  logic       pkt_exit;
  logic [1:0] locked;
  logic [1:0] key_hit;
  logic [1:0] reload;
  logic [1:0] accept_vec;
  logic [3:0] enc_word;

  function automatic logic [3:0] rotl1(input logic [3:0] k);
    return {k[2:0], k[3]};
  endfunction

`ifdef NIBBLE_ENC_PARITY_EN
  logic acc_par;

  function automatic logic par_err(input logic [3:0] w, input logic p);
    return (^w) ^ p;
  endfunction

  assign acc_par = acc_ch ? req1_par : req0_par;
`endif

  // Arbitration, lock handshake and packet-exit decode
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    grant      = 1'b0;
    win        = 1'b0;
    acc        = 1'b0;
    pkt_exit   = 1'b0;
    acc_ch     = (state == LOCK1);
    acc_word   = acc_ch ? req1_word : req0_word;
    acc_last   = acc_ch ? req1_last : req0_last;
    slot_free  = !out_valid || out_ready;
    burst_hit  = (burst_cnt + 4'd1) == 4'(MAX_BURST);
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          grant     = 1'b1;
          win       = (req0_valid && req1_valid) ? rr_prio : req1_valid;
          state_nxt = win ? LOCK1 : LOCK0;
        end else begin
          state_nxt = IDLE;
        end
      end
      LOCK0: begin
        req0_ready = slot_free;
        acc        = req0_valid && slot_free;
        pkt_exit   = acc && (acc_last || burst_hit);
        state_nxt  = pkt_exit ? IDLE : LOCK0;
      end
      LOCK1: begin
        req1_ready = slot_free;
        acc        = req1_valid && slot_free;
        pkt_exit   = acc && (acc_last || burst_hit);
        state_nxt  = pkt_exit ? IDLE : LOCK1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign locked     = {state == LOCK1, state == LOCK0};
  assign key_hit    = key_load ? (key_sel ? 2'b10 : 2'b01) : 2'b00;
  assign reload     = grant ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign accept_vec = acc ? (acc_ch ? 2'b10 : 2'b01) : 2'b00;
  assign busy       = (state != IDLE) || out_valid;

  FourbitEncoder u_enc (
    .data (acc_word),
    .key  (work_key[acc_ch]),
    .enc  (enc_word)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Round-robin pointer and per-grant burst counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_prio   <= 1'b0;
      burst_cnt <= 4'd0;
    end else if (pkt_exit) begin
      rr_prio   <= ~acc_ch;
      burst_cnt <= 4'd0;
    end else if (acc) begin
      burst_cnt <= burst_cnt + 4'd1;
    end else begin
      burst_cnt <= burst_cnt;
    end
  end

  // Key storage: a key_load into an idle channel beats the packet-start reload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_key   <= {2{RESET_KEY}};
      work_key   <= {2{RESET_KEY}};
      mid_packet <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (key_hit[i]) begin
          base_key[i] <= key_in;
        end
        if (key_hit[i] && !mid_packet[i] && !locked[i]) begin
          work_key[i] <= key_in;
        end else if (reload[i] && !mid_packet[i]) begin
          work_key[i] <= base_key[i];
        end else if (accept_vec[i] && KEY_ROTATE) begin
          work_key[i] <= rotl1(work_key[i]);
        end
        if (accept_vec[i] && pkt_exit) begin
          mid_packet[i] <= !acc_last;
        end
      end
    end
  end

  // Output register: holds while stalled, drops valid only when drained with no refill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_word  <= 4'h0;
      out_ch    <= 1'b0;
      out_last  <= 1'b0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_word  <= enc_word;
      out_ch    <= acc_ch;
      out_last  <= acc_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

`ifdef NIBBLE_ENC_PARITY_EN
  // Parity flag registered alongside out_word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_err <= 1'b0;
    end else if (acc) begin
      out_err <= par_err(acc_word, acc_par);
    end else begin
      out_err <= out_err;
    end
  end
`endif

endmodule

// File: tb/tb_nibble_enc_arbiter.sv
// Self-checking bench for nibble_enc_arbiter: packet-level key model plus scoreboard,
// and directed scenarios with hand-computed expected output words.

module tb_nibble_enc_arbiter;

  localparam int RESET_KEY_TB = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req0_ready, req0_last = 1'b0;
  logic [3:0] req0_word = 4'h0;
  logic       req1_valid = 1'b0, req1_ready, req1_last = 1'b0;
  logic [3:0] req1_word = 4'h0;
  logic       key_load = 1'b0, key_sel = 1'b0;
  logic [3:0] key_in = 4'h0;
  logic       out_valid, out_ready = 1'b1, out_ch, out_last, busy;
  logic [3:0] out_word;

  always #5 clk = ~clk;

  nibble_enc_arbiter #(.KEY_ROTATE(1'b1), .RESET_KEY(4'h0), .MAX_BURST(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_word(req0_word), .req0_last(req0_last),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_word(req1_word), .req1_last(req1_last),
    .key_load(key_load), .key_sel(key_sel), .key_in(key_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_ch(out_ch), .out_last(out_last), .busy(busy)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [4:0] q0[$];
  logic [4:0] q1[$];
  logic [5:0] exp_q[$];
  int log_w[$], log_c[$], log_l[$], log_t[$];

  int m_base[2];
  int m_work[2];
  bit m_inpkt[2];
  bit acc0 = 1'b0, acc1 = 1'b0;
  bit hold_prev = 1'b0;
  int prev_w, prev_c, prev_l;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d", name, act, req);
    end
  endtask

  function automatic int lw(input int i); return (i < log_w.size()) ? log_w[i] : -1; endfunction
  function automatic int lc(input int i); return (i < log_c.size()) ? log_c[i] : -1; endfunction
  function automatic int ll(input int i); return (i < log_l.size()) ? log_l[i] : -1; endfunction
  function automatic int lt(input int i); return (i < log_t.size()) ? log_t[i] : -1000; endfunction

  // Packet-level key model: a packet starts on the base key, then the key rotates per word
  task automatic m_accept(input int ch, input int word, input int last);
    int enc;
    logic [5:0] e;
    if (!m_inpkt[ch]) m_work[ch] = m_base[ch];
    enc = (word ^ m_work[ch]) & 15;
    e = {ch[0], last[0], enc[3:0]};
    exp_q.push_back(e);
    m_work[ch] = ((m_work[ch] << 1) | (m_work[ch] >> 3)) & 15;
    m_inpkt[ch] = (last == 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: scoreboard, output stability and model update at the negedge
  always @(negedge clk) begin
    logic [5:0] e;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_base[i] = RESET_KEY_TB; m_work[i] = RESET_KEY_TB; m_inpkt[i] = 1'b0;
      end
      exp_q.delete();
      hold_prev = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_word", int'(out_word), prev_w);
        chk("hold_ch", int'(out_ch), prev_c);
        chk("hold_last", int'(out_last), prev_l);
      end
      chk("single_ready", int'(req0_ready & req1_ready), 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_word", int'(out_word), int'(e[3:0]));
          chk("sb_ch", int'(out_ch), int'(e[5]));
          chk("sb_last", int'(out_last), int'(e[4]));
        end
        log_w.push_back(int'(out_word)); log_c.push_back(int'(out_ch));
        log_l.push_back(int'(out_last)); log_t.push_back(cyc);
      end
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      if (acc0) m_accept(0, int'(req0_word), int'(req0_last));
      if (acc1) m_accept(1, int'(req1_word), int'(req1_last));
      if (key_load) m_base[key_sel] = int'(key_in);
      hold_prev = out_valid && !out_ready;
      prev_w = int'(out_word); prev_c = int'(out_ch); prev_l = int'(out_last);
    end
  end

  // Requester drivers: present queue heads, advance on an observed accept
  initial forever begin
    @(posedge clk); #2;
    if (acc0 && q0.size() > 0) void'(q0.pop_front());
    if (acc1 && q1.size() > 0) void'(q1.pop_front());
    if (q0.size() > 0) begin req0_valid = 1'b1; {req0_last, req0_word} = q0[0]; end
    else begin req0_valid = 1'b0; req0_last = 1'b0; req0_word = 4'h0; end
    if (q1.size() > 0) begin req1_valid = 1'b1; {req1_last, req1_word} = q1[0]; end
    else begin req1_valid = 1'b0; req1_last = 1'b0; req1_word = 4'h0; end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic kload(input logic ch, input logic [3:0] k);
    key_load = 1'b1; key_sel = ch; key_in = k;
    step(1);
    key_load = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; q0.delete(); q1.delete();
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic drain(input string name);
    int c = 0;
    while ((q0.size() > 0 || q1.size() > 0 || out_valid || exp_q.size() > 0) && c < 60) begin
      step(1); c++;
    end
    chk(name, int'(c < 60), 1);
    chk({name, "_busy"}, int'(busy), 0);
  endtask

  task automatic wait_valid(input string name);
    int c = 0;
    while (!out_valid && c < 20) begin step(1); c++; end
    chk(name, int'(out_valid), 1);
  endtask

  initial begin
    int b;
    #200000;
    $display("FAIL watchdog: actual timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    step(2);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_ready0", int'(req0_ready), 0);
    chk("rst_ready1", int'(req1_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_word", int'(out_word), 0);
    rst_n = 1'b1;
    step(1);

    // key 3, words A then 5: A^3 = 9, key rotates to 6, 5^6 = 3
    kload(1'b0, 4'h3);
    b = log_w.size();
    q0.push_back({1'b0, 4'hA}); q0.push_back({1'b1, 4'h5});
    drain("t1_drain");
    chk("t1_w0", lw(b), 9);      chk("t1_w1", lw(b + 1), 3);
    chk("t1_c0", lc(b), 0);      chk("t1_c1", lc(b + 1), 0);
    chk("t1_l0", ll(b), 0);      chk("t1_l1", ll(b + 1), 1);
    chk("t1_gap", lt(b + 1) - lt(b), 1);

    // both channels from reset, keys 0: grant order 0,1,0,1 with an IDLE cycle between words
    do_reset();
    b = log_w.size();
    q0.push_back({1'b1, 4'hA}); q0.push_back({1'b1, 4'hB});
    q1.push_back({1'b1, 4'hC}); q1.push_back({1'b1, 4'hD});
    drain("t2_drain");
    chk("t2_w0", lw(b), 10); chk("t2_w1", lw(b + 1), 12);
    chk("t2_w2", lw(b + 2), 11); chk("t2_w3", lw(b + 3), 13);
    chk("t2_c0", lc(b), 0); chk("t2_c1", lc(b + 1), 1);
    chk("t2_c2", lc(b + 2), 0); chk("t2_c3", lc(b + 3), 1);
    chk("t2_gap", lt(b + 2) - lt(b + 1), 2);

    // stall: key1 = 1, words 6,9 -> 7, then 9^2 = B one cycle after out_ready returns
    kload(1'b1, 4'h1);
    out_ready = 1'b0;
    b = log_w.size();
    q1.push_back({1'b0, 4'h6}); q1.push_back({1'b1, 4'h9});
    wait_valid("t3_valid");
    for (int i = 0; i < 3; i++) begin
      chk("t3_stall_ready1", int'(req1_ready), 0);
      chk("t3_stall_word", int'(out_word), 7);
      step(1);
    end
    out_ready = 1'b1;
    drain("t3_drain");
    chk("t3_w0", lw(b), 7); chk("t3_w1", lw(b + 1), 11);
    chk("t3_gap", lt(b + 1) - lt(b), 1);

    // MAX_BURST = 2: key0 = 8 -> 1^8 = 9, 2^1 = 3, ch1 4^1 = 5, then ch0 resumes 3^2 = 1
    kload(1'b0, 4'h8);
    b = log_w.size();
    q0.push_back({1'b0, 4'h1}); q0.push_back({1'b0, 4'h2}); q0.push_back({1'b1, 4'h3});
    q1.push_back({1'b1, 4'h4});
    drain("t4_drain");
    chk("t4_w0", lw(b), 9); chk("t4_w1", lw(b + 1), 3);
    chk("t4_w2", lw(b + 2), 5); chk("t4_w3", lw(b + 3), 1);
    chk("t4_c1", lc(b + 1), 0); chk("t4_c2", lc(b + 2), 1); chk("t4_c3", lc(b + 3), 0);
    chk("t4_l1", ll(b + 1), 0); chk("t4_l3", ll(b + 3), 1);

    // key_load F while ch1 is locked: packet keeps key 1 (outputs 1, 2), next packet gives F
    out_ready = 1'b0;
    b = log_w.size();
    q1.push_back({1'b0, 4'h0}); q1.push_back({1'b1, 4'h0});
    wait_valid("t5_valid");
    kload(1'b1, 4'hF);
    out_ready = 1'b1;
    drain("t5_drain_a");
    q1.push_back({1'b1, 4'h0});
    drain("t5_drain_b");
    chk("t5_w0", lw(b), 1); chk("t5_w1", lw(b + 1), 2); chk("t5_w2", lw(b + 2), 15);

    // reset mid-packet: output cleared at once, next ch0 word uses the reset key
    kload(1'b0, 4'h5);
    q0.push_back({1'b0, 4'h1}); q0.push_back({1'b0, 4'h2});
    wait_valid("t6_valid");
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", int'(out_valid), 0);
    chk("t6_async_ready0", int'(req0_ready), 0);
    chk("t6_async_busy", int'(busy), 0);
    q0.delete(); q1.delete();
    step(2);
    rst_n = 1'b1;
    step(1);
    b = log_w.size();
    q0.push_back({1'b1, 4'h6});
    drain("t6_drain");
    chk("t6_w0", lw(b), 6); chk("t6_c0", lc(b), 0); chk("t6_l0", ll(b), 1);

    chk("final_scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
